multicycle_addsub: RTL and testbench

//  Parametrised add/subtract unit with start/done handshake; next generation of the 4-bit

---
 rtl/multicycle_addsub.sv | 107 ++++++++++
 tb/tb_multicycle_addsub.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_addsub.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per clock, LSB slice first.
// start/done handshake; result, carry_out and overflow change only when an operation completes.
//  state | meaning
//  IDLE  | waiting for start; outputs hold the last completed result
//  RUN   | one slice per clock, carry held between slices
module multicycle_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [SW-1:0] LAST = SW'(NCH - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("multicycle_addsub: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t                        state;
    logic [NCH-1:0][CHUNK-1:0]     op_a;
    logic [NCH-1:0][CHUNK-1:0]     op_b;
    logic [NCH-1:0][CHUNK-1:0]     partial;
    logic [NCH-1:0][CHUNK-1:0]     partial_nxt;
    logic                          carry;
    logic [SW-1:0]                 slice;
    logic [CHUNK-1:0]              a_sl;
    logic [CHUNK-1:0]              b_sl;
    logic [CHUNK:0]                sl_sum;
    logic                          msb_cin;

    always_comb begin
        a_sl        = op_a[slice];
        b_sl        = op_b[slice];
        sl_sum      = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
        partial_nxt = partial;
        partial_nxt[slice] = sl_sum[CHUNK-1:0];
    end

    // Carry into the top bit of the current slice; only meaningful in the final slice.
    if (CHUNK == 1) begin : g_cin_single
        assign msb_cin = carry;
    end else begin : g_cin_multi
        logic [CHUNK-1:0] lo_sum;
        assign lo_sum  = {1'b0, a_sl[CHUNK-2:0]} + {1'b0, b_sl[CHUNK-2:0]}
                       + {{(CHUNK-1){1'b0}}, carry};
        assign msb_cin = lo_sum[CHUNK-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            partial   <= '0;
            carry     <= 1'b0;
            slice     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a    <= A;
                        op_b    <= B ^ {WIDTH{sub}};
                        carry   <= sub;
                        slice   <= '0;
                        partial <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    partial <= partial_nxt;
                    carry   <= sl_sum[CHUNK];
                    slice   <= slice + SW'(1);
                    if (slice == LAST) begin
                        result    <= partial_nxt;
                        carry_out <= sl_sum[CHUNK];
                        overflow  <= msb_cin ^ sl_sum[CHUNK];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub: CHUNK=4 (four-cycle) and CHUNK=16 (single-cycle) instances
// share operands; each has its own start line.
module tb_multicycle_addsub;

    logic        clk;
    logic        reset;
    logic        start_n, start_w;
    logic        sub;
    logic [15:0] A, B;
    logic        busy_n, done_n, co_n, ov_n;
    logic [15:0] res_n;
    logic        busy_w, done_w, co_w, ov_w;
    logic [15:0] res_w;

    int errors = 0;
    int checks = 0;
    logic [15:0] prev_res [2];

    multicycle_addsub #(.WIDTH(16), .CHUNK(4)) dut_n (
        .clk(clk), .reset(reset), .start(start_n), .sub(sub), .A(A), .B(B),
        .busy(busy_n), .done(done_n), .result(res_n), .carry_out(co_n), .overflow(ov_n)
    );

    multicycle_addsub #(.WIDTH(16), .CHUNK(16)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .sub(sub), .A(A), .B(B),
        .busy(busy_w), .done(done_w), .result(res_w), .carry_out(co_w), .overflow(ov_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        bit          co;
        bit          ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; returns {carry_out, overflow, result}.
    function automatic logic [17:0] model(input bit s, input logic [15:0] a, input logic [15:0] b);
        int ua, ub, sa, sb, sr;
        logic [15:0] r;
        bit co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            r  = 16'(ua - ub);
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = 16'(ua + ub);
            co = (ua + ub) > 65535;
            sr = sa + sb;
        end
        ov = (sr > 32767) || (sr < -32768);
        return {co, ov, r};
    endfunction

    function automatic logic f_done(input bit w);  return w ? done_w : done_n; endfunction
    function automatic logic f_busy(input bit w);  return w ? busy_w : busy_n; endfunction
    function automatic logic [15:0] f_res(input bit w); return w ? res_w : res_n; endfunction
    function automatic logic f_co(input bit w);    return w ? co_w : co_n; endfunction
    function automatic logic f_ov(input bit w);    return w ? ov_w : ov_n; endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy_n"}, 32'(busy_n), 32'd0);
        check({tag, "_done_n"}, 32'(done_n), 32'd0);
        check({tag, "_res_n"},  32'(res_n),  32'd0);
        check({tag, "_co_n"},   32'(co_n),   32'd0);
        check({tag, "_ov_n"},   32'(ov_n),   32'd0);
        check({tag, "_busy_w"}, 32'(busy_w), 32'd0);
        check({tag, "_res_w"},  32'(res_w),  32'd0);
        check({tag, "_co_w"},   32'(co_w),   32'd0);
        check({tag, "_ov_w"},   32'(ov_w),   32'd0);
    endtask

    // One full operation with latency, busy-length, output-hold and result checks.
    task automatic do_op(input bit w, input bit s, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input bit eco, input bit eov, input string tag);
        int cnt, busy_cnt, lat;
        bit hold_ok;
        lat = w ? 1 : 4;
        @(negedge clk);
        A = a; B = b; sub = s;
        if (w) start_w = 1'b1; else start_n = 1'b1;
        @(negedge clk);
        start_n = 1'b0; start_w = 1'b0;
        A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
        cnt = 0; busy_cnt = 0; hold_ok = 1'b1;
        while (!f_done(w) && cnt < 20) begin
            if (f_busy(w)) busy_cnt++;
            if (f_res(w) !== prev_res[w]) hold_ok = 1'b0;
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(lat));
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'(lat));
        check({tag, "_hold"}, 32'(hold_ok), 32'd1);
        check({tag, "_result"}, 32'(f_res(w)), 32'(er));
        check({tag, "_carry"}, 32'(f_co(w)), 32'(eco));
        check({tag, "_ovf"}, 32'(f_ov(w)), 32'(eov));
        prev_res[w] = er;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(f_done(w)), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        logic [17:0] m;
        logic [15:0] ra, rb;
        bit rs;
        int cnt;

        vecs[0] = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h0F0F, 16'h0101, 16'h1010, 1'b0, 1'b0};

        reset = 1'b0; start_n = 1'b0; start_w = 1'b0; sub = 1'b0; A = '0; B = '0;
        prev_res[0] = '0; prev_res[1] = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            do_op(1'b0, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].co, vecs[i].ov,
                  $sformatf("vec%0d_n", i));
            do_op(1'b1, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].co, vecs[i].ov,
                  $sformatf("vec%0d_w", i));
        end

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            m = model(rs, ra, rb);
            do_op(1'($urandom_range(0, 1)), rs, ra, rb, m[15:0], m[17], m[16],
                  $sformatf("rand%0d", i));
        end

        // start pulses while busy are ignored; start in the done cycle launches the next op
        @(negedge clk);
        A = 16'h0F0F; B = 16'h0101; sub = 1'b0; start_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            A = i[0] ? 16'h1234 : 16'hFFFF; B = 16'hFFFF; sub = ~sub; start_n = 1'b1;
        end
        @(negedge clk);
        start_n = 1'b0;
        check("busy_ign_early_done", 32'(done_n), 32'd0);
        @(negedge clk);
        check("busy_ign_done", 32'(done_n), 32'd1);
        check("busy_ign_result", 32'(res_n), 32'h1010);
        check("busy_ign_carry", 32'(co_n), 32'd0);
        A = 16'h1000; B = 16'h0234; sub = 1'b0; start_n = 1'b1;
        @(negedge clk);
        start_n = 1'b0;
        check("b2b_single_done", 32'(done_n), 32'd0);
        check("b2b_busy", 32'(busy_n), 32'd1);
        cnt = 0;
        while (!done_n && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_latency", 32'(cnt), 32'd4);
        check("b2b_result", 32'(res_n), 32'h1234);
        prev_res[0] = 16'h1234;
        @(negedge clk);

        // asynchronous reset mid-operation
        A = 16'hFFFF; B = 16'hFFFF; sub = 1'b0; start_n = 1'b1; start_w = 1'b1;
        @(negedge clk);
        start_n = 1'b0; start_w = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_no_done%0d", i), 32'(done_n), 32'd0);
        end
        reset = 1'b1;
        prev_res[0] = '0; prev_res[1] = '0;
        do_op(1'b0, 1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
